mem_port_arbiter: RTL and testbench

//  Shares one synchronous single-ported memory between instruction fetch (IF, read-only)
//  and data access (DM, load/store driven by the decoded mem_wen/wb_sel path).

---
 rtl/mem_port_arbiter.sv | 109 ++++++++++
 tb/tb_mem_port_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported synchronous memory between instruction fetch and data access.
// Optional perf counters are built only when MEM_ARB_PERF_EN is defined.
module mem_port_arbiter #(
  parameter int ADDR_W       = 14,
  parameter int READ_LATENCY = 1,
  parameter int MAX_STREAK   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              if_req_valid,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_req_ready,
  output logic              if_rsp_valid,
  output logic [31:0]       if_rsp_data,
  input  logic              dm_req_valid,
  input  logic [3:0]        dm_req_we,
  input  logic [ADDR_W-1:0] dm_req_addr,
  input  logic [31:0]       dm_req_wdata,
  output logic              dm_req_ready,
  output logic              dm_rsp_valid,
  output logic [31:0]       dm_rsp_data,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       if_stall_cnt,
  output logic [31:0]       conflict_cnt
);

  localparam int SW = $clog2(MAX_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

  logic [SW-1:0]           r_streak;
  logic [READ_LATENCY-1:0] r_tag_v;
  logic [READ_LATENCY-1:0] r_tag_if;

  logic w_if_pri;
  logic w_if_acc;
  logic w_dm_acc;
  logic w_rd_acc;

  // IF only takes priority once DM has used up its streak budget while IF waited
  assign w_if_pri     = if_req_valid && !flush && (r_streak == STREAK_MAX);
  assign dm_req_ready = rst_n && dm_req_valid && !w_if_pri;
  assign if_req_ready = rst_n && if_req_valid && !flush && !(dm_req_valid && !w_if_pri);

  assign w_dm_acc = dm_req_valid && dm_req_ready;
  assign w_if_acc = if_req_valid && if_req_ready;
  assign w_rd_acc = w_if_acc || (w_dm_acc && (dm_req_we == 4'b0000));

  assign mem_en    = w_if_acc || w_dm_acc;
  assign mem_we    = w_dm_acc ? dm_req_we : 4'b0000;
  assign mem_addr  = w_dm_acc ? dm_req_addr : if_req_addr;
  assign mem_wdata = dm_req_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_streak <= '0;
    end else if (w_if_acc || !if_req_valid) begin
      r_streak <= '0;
    end else if (w_dm_acc && (r_streak != STREAK_MAX)) begin
      r_streak <= r_streak + 1'b1;
    end
  end

  // Tag pipe mirrors the memory read latency; flush kills IF-owned entries in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_v  <= '0;
      r_tag_if <= '0;
    end else begin
      for (int i = READ_LATENCY - 1; i > 0; i--) begin
        r_tag_v[i]  <= r_tag_v[i-1] && !(flush && r_tag_if[i-1]);
        r_tag_if[i] <= r_tag_if[i-1];
      end
      r_tag_v[0]  <= w_rd_acc;
      r_tag_if[0] <= w_if_acc;
    end
  end

  assign if_rsp_valid = r_tag_v[READ_LATENCY-1] && r_tag_if[READ_LATENCY-1] && !flush;
  assign dm_rsp_valid = r_tag_v[READ_LATENCY-1] && !r_tag_if[READ_LATENCY-1];
  assign if_rsp_data  = mem_rdata;
  assign dm_rsp_data  = mem_rdata;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] r_if_stall_cnt;
  logic [31:0] r_conflict_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_stall_cnt <= '0;
      r_conflict_cnt <= '0;
    end else begin
      if (if_req_valid && !if_req_ready) r_if_stall_cnt <= r_if_stall_cnt + 32'd1;
      if (if_req_valid && dm_req_valid)  r_conflict_cnt <= r_conflict_cnt + 32'd1;
    end
  end

  assign if_stall_cnt = r_if_stall_cnt;
  assign conflict_cnt = r_conflict_cnt;
`else
  assign if_stall_cnt = 32'd0;
  assign conflict_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Random and directed stimulus for mem_port_arbiter, checked against a transaction-level model
// with an expected-response queue and a shadow memory.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 14;
  localparam int LAT    = 2;
  localparam int MAXS   = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              if_req_valid;
  logic [ADDR_W-1:0] if_req_addr;
  logic              if_req_ready;
  logic              if_rsp_valid;
  logic [31:0]       if_rsp_data;
  logic              dm_req_valid;
  logic [3:0]        dm_req_we;
  logic [ADDR_W-1:0] dm_req_addr;
  logic [31:0]       dm_req_wdata;
  logic              dm_req_ready;
  logic              dm_rsp_valid;
  logic [31:0]       dm_rsp_data;
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic [31:0]       if_stall_cnt;
  logic [31:0]       conflict_cnt;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .READ_LATENCY(LAT), .MAX_STREAK(MAXS)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .dm_req_valid(dm_req_valid), .dm_req_we(dm_req_we), .dm_req_addr(dm_req_addr),
    .dm_req_wdata(dm_req_wdata), .dm_req_ready(dm_req_ready),
    .dm_rsp_valid(dm_rsp_valid), .dm_rsp_data(dm_rsp_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .if_stall_cnt(if_stall_cnt), .conflict_cnt(conflict_cnt)
  );

  // synchronous RAM with LAT-cycle read pipe
  logic [31:0] ram [32];
  logic [31:0] rpipe [LAT];

  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) ram[mem_addr[4:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
      rpipe[0] <= ram[mem_addr[4:0]];
    end else begin
      rpipe[0] <= 32'hDEAD_BEEF;
    end
    for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign mem_rdata = rpipe[LAT-1];

  // reference model state
  typedef struct {
    bit          is_if;
    logic [31:0] data;
    int          due;
  } rsp_t;

  rsp_t        exp_q[$];
  logic [31:0] shadow [32];
  int          m_streak;
  logic [31:0] m_stall;
  logic [31:0] m_conf;
  int          cyc;
  int          n_checks;
  int          n_fail;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_streak = 0;
    m_stall  = 0;
    m_conf   = 0;
  endtask

  // called at negedge: inputs are stable, compare then advance the model by one cycle
  task automatic step_model();
    bit   if_wins_by_wait, dm_acc, if_acc, got_rsp, exp_if_v, exp_dm_v;
    logic [31:0] exp_data;
    rsp_t e;
    int   k;
`ifdef MEM_ARB_PERF_EN
    chk("conflict_cnt", conflict_cnt, m_conf);
    chk("if_stall_cnt", if_stall_cnt, m_stall);
`else
    chk("conflict_cnt_off", conflict_cnt, 32'd0);
    chk("if_stall_cnt_off", if_stall_cnt, 32'd0);
`endif
    if_wins_by_wait = if_req_valid && !flush && (m_streak >= MAXS);
    dm_acc = dm_req_valid && !if_wins_by_wait;
    if_acc = if_req_valid && !flush && !dm_acc;

    chk("dm_req_ready", 32'(dm_req_ready), 32'(dm_acc));
    chk("if_req_ready", 32'(if_req_ready), 32'(if_acc));
    chk("mem_en", 32'(mem_en), 32'(dm_acc || if_acc));
    chk("mem_we", 32'(mem_we), dm_acc ? 32'(dm_req_we) : 32'd0);
    if (dm_acc) chk("mem_addr_dm", 32'(mem_addr), 32'(dm_req_addr));
    else if (if_acc) chk("mem_addr_if", 32'(mem_addr), 32'(if_req_addr));
    if (dm_acc && dm_req_we != 4'b0) chk("mem_wdata", mem_wdata, dm_req_wdata);

    got_rsp  = 0;
    exp_if_v = 0;
    exp_dm_v = 0;
    exp_data = '0;
    k = -1;
    foreach (exp_q[i]) if (exp_q[i].due == cyc && k < 0) k = i;
    if (k >= 0) begin
      e = exp_q[k];
      exp_q.delete(k);
      got_rsp  = 1;
      exp_data = e.data;
      if (e.is_if) exp_if_v = !flush;
      else         exp_dm_v = 1;
    end
    chk("if_rsp_valid", 32'(if_rsp_valid), 32'(exp_if_v));
    chk("dm_rsp_valid", 32'(dm_rsp_valid), 32'(exp_dm_v));
    if (got_rsp && exp_if_v) chk("if_rsp_data", if_rsp_data, exp_data);
    if (got_rsp && exp_dm_v) chk("dm_rsp_data", dm_rsp_data, exp_data);

    if (flush) begin
      for (int i = exp_q.size() - 1; i >= 0; i--)
        if (exp_q[i].is_if) exp_q.delete(i);
    end

    if (if_acc) exp_q.push_back('{1'b1, shadow[if_req_addr[4:0]], cyc + LAT});
    if (dm_acc) begin
      if (dm_req_we == 4'b0)
        exp_q.push_back('{1'b0, shadow[dm_req_addr[4:0]], cyc + LAT});
      else
        for (int b = 0; b < 4; b++)
          if (dm_req_we[b]) shadow[dm_req_addr[4:0]][8*b +: 8] = dm_req_wdata[8*b +: 8];
    end

    if (if_acc || !if_req_valid) m_streak = 0;
    else if (dm_acc && m_streak < MAXS) m_streak++;
    if (if_req_valid && !if_acc) m_stall++;
    if (if_req_valid && dm_req_valid) m_conf++;
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    step_model();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit ifv, input int ifa, input bit dmv, input logic [3:0] we,
                       input int dma, input logic [31:0] wd, input bit fl);
    if_req_valid = ifv;
    if_req_addr  = ADDR_W'(ifa);
    dm_req_valid = dmv;
    dm_req_we    = we;
    dm_req_addr  = ADDR_W'(dma);
    dm_req_wdata = wd;
    flush        = fl;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_if_ready"}, 32'(if_req_ready), 32'd0);
    chk({tag, "_dm_ready"}, 32'(dm_req_ready), 32'd0);
    chk({tag, "_if_rsp"}, 32'(if_rsp_valid), 32'd0);
    chk({tag, "_dm_rsp"}, 32'(dm_rsp_valid), 32'd0);
    chk({tag, "_mem_en"}, 32'(mem_en), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_stall"}, if_stall_cnt, 32'd0);
    chk({tag, "_conf"}, conflict_cnt, 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    for (int i = 0; i < 32; i++) begin
      ram[i]    = $urandom;
      shadow[i] = ram[i];
    end
    for (int i = 0; i < LAT; i++) rpipe[i] = '0;
    model_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 4'b0, 0, 32'h0, 0);
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    rst_n = 1'b1;

    // both requesters valid for 10 cycles: DM x4 then IF, repeating
    for (int i = 0; i < 10; i++) begin
      drive(1, i, 1, 4'b0, 16 + i, 32'h0, 0);
      tick();
    end
`ifdef MEM_ARB_PERF_EN
    chk("conf_after_10", conflict_cnt, 32'd10);
    chk("stall_after_10", if_stall_cnt, 32'd8);
`endif

    // IF-only back-to-back reads
    for (int i = 0; i < 4; i++) begin
      drive(1, i, 0, 4'b0, 0, 32'h0, 0);
      tick();
    end

    // partial store, then IF read same word next cycle, then DM load
    drive(0, 0, 1, 4'b0011, 5'h10, 32'hA5A5_1234, 0);
    tick();
    drive(1, 5'h10, 0, 4'b0, 0, 32'h0, 0);
    tick();
    drive(0, 0, 1, 4'b0, 5'h10, 32'h0, 0);
    tick();

    // IF reads in flight, flush together with a DM load
    drive(1, 3, 0, 4'b0, 0, 32'h0, 0);
    tick();
    drive(1, 4, 0, 4'b0, 0, 32'h0, 0);
    tick();
    drive(1, 5, 1, 4'b0, 7, 32'h0, 1);
    tick();
    for (int i = 0; i < LAT + 2; i++) begin
      drive(0, 0, 0, 4'b0, 0, 32'h0, 0);
      tick();
    end

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 31),
            $urandom_range(0, 9) < 6,
            ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0,
            $urandom_range(0, 31), $urandom, $urandom_range(0, 19) == 0);
      tick();
    end

    // reset with reads outstanding
    drive(1, 1, 1, 4'b0, 2, 32'h0, 0);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check_quiet("midrst");
    @(posedge clk);
    #1;
    drive(0, 0, 0, 4'b0, 0, 32'h0, 0);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < LAT + 4; i++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
